// File: rtl/ahb_bram_ctrl.sv
// ---------------------------------------------------------------------------
// ahb_bram_ctrl
//
// AHB-Lite slave in front of a simple dual-port block RAM used as code/data
// memory. Port A is the write port (per-byte enables), port B is the read
// port with a one-cycle registered output. All transfers complete with zero
// wait states. Misaligned or oversized transfers get a two-cycle ERROR
// response.
//
// FSM states (error response sequencer):
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | normal operation, OKAY response
//   ST_ERR1  | first ERROR cycle, HREADYOUT low, no new transfer accepted
//   ST_ERR2  | second ERROR cycle, HREADYOUT high, next transfer accepted
//
// Ports:
//   clka, rsta        clock (shared with the RAM), synchronous active-high reset
//   HSEL..HREADY      AHB-Lite slave inputs (address and data phase)
//   HREADYOUT, HRESP  slave handshake / response
//   HRDATA            read data, zero when no read data phase is active
//   ram_addra/dina/wea  RAM write port A
//   ram_addrb         RAM read port B address (combinational from HADDR)
//   ram_doutb         RAM registered read data
// ---------------------------------------------------------------------------
module ahb_bram_ctrl #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clka,
    input  logic                  rsta,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [31:0]           HRDATA,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [31:0]           ram_dina,
    output logic [3:0]            ram_wea,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    input  logic [31:0]           ram_doutb
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } state_t;

    state_t                state_q, state_d;

    logic                  wr_pend_q, wr_pend_d;
    logic                  rd_pend_q, rd_pend_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [3:0]            wr_mask_q, wr_mask_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;

    logic                  fwd_valid_q, fwd_valid_d;
    logic [ADDR_WIDTH-1:0] fwd_addr_q, fwd_addr_d;
    logic [31:0]           fwd_data_q, fwd_data_d;
    logic [3:0]            fwd_mask_q, fwd_mask_d;

    logic                  accept;
    logic                  xfer_bad;
    logic [3:0]            lane_mask;
    logic [ADDR_WIDTH-1:0] haddr_word;

    // Upper address bits alias the RAM; HTRANS[0] only separates NONSEQ/SEQ.
    logic                  unused_inputs;
    assign unused_inputs = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

    assign haddr_word = HADDR[ADDR_WIDTH+1:2];
    assign ram_addrb  = haddr_word;

    // No transfer is taken during ERR1: the bus is stalled by HREADYOUT = 0.
    assign accept = HSEL & HREADY & HTRANS[1] & (state_q != ST_ERR1);

    // ------------------------------------------------------------------
    // Address-phase decode: byte lanes and alignment check
    // ------------------------------------------------------------------
    always_comb begin
        lane_mask = 4'b0000;
        xfer_bad  = 1'b0;
        case (HSIZE)
            3'd0: lane_mask = 4'b0001 << HADDR[1:0];
            3'd1: begin
                lane_mask = HADDR[1] ? 4'b1100 : 4'b0011;
                xfer_bad  = HADDR[0];
            end
            3'd2: begin
                lane_mask = 4'b1111;
                xfer_bad  = |HADDR[1:0];
            end
            default: xfer_bad = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Error FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_ERR2: state_d = (accept && xfer_bad) ? ST_ERR1 : ST_IDLE;
            ST_ERR1:          state_d = ST_ERR2;
            default:          state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Data-phase bookkeeping and write forwarding capture
    // ------------------------------------------------------------------
    always_comb begin
        wr_pend_d = accept & ~xfer_bad & HWRITE;
        rd_pend_d = accept & ~xfer_bad & ~HWRITE;
        wr_addr_d = wr_addr_q;
        wr_mask_d = wr_mask_q;
        rd_addr_d = rd_addr_q;
        if (wr_pend_d) begin
            wr_addr_d = haddr_word;
            wr_mask_d = lane_mask;
        end
        if (rd_pend_d) begin
            rd_addr_d = haddr_word;
        end

        // A read issued during a write data phase sees stale RAM contents;
        // remember that write for exactly one cycle so the read can merge it.
        fwd_valid_d = wr_pend_q;
        fwd_addr_d  = fwd_addr_q;
        fwd_data_d  = fwd_data_q;
        fwd_mask_d  = fwd_mask_q;
        if (wr_pend_q) begin
            fwd_addr_d = wr_addr_q;
            fwd_data_d = HWDATA;
            fwd_mask_d = wr_mask_q;
        end
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            state_q     <= ST_IDLE;
            wr_pend_q   <= 1'b0;
            rd_pend_q   <= 1'b0;
            wr_addr_q   <= '0;
            wr_mask_q   <= 4'b0000;
            rd_addr_q   <= '0;
            fwd_valid_q <= 1'b0;
            fwd_addr_q  <= '0;
            fwd_data_q  <= 32'h0;
            fwd_mask_q  <= 4'b0000;
        end else begin
            state_q     <= state_d;
            wr_pend_q   <= wr_pend_d;
            rd_pend_q   <= rd_pend_d;
            wr_addr_q   <= wr_addr_d;
            wr_mask_q   <= wr_mask_d;
            rd_addr_q   <= rd_addr_d;
            fwd_valid_q <= fwd_valid_d;
            fwd_addr_q  <= fwd_addr_d;
            fwd_data_q  <= fwd_data_d;
            fwd_mask_q  <= fwd_mask_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // rsta gates the strobes combinationally so a write whose data phase
    // overlaps reset never reaches the RAM.
    assign ram_addra = wr_addr_q;
    assign ram_dina  = HWDATA;
    assign ram_wea   = rsta ? 4'b0000 : (wr_mask_q & {4{wr_pend_q}});

    assign HREADYOUT = rsta | (state_q != ST_ERR1);
    assign HRESP     = ~rsta & (state_q != ST_IDLE);

    always_comb begin
        HRDATA = 32'h0;
        if (!rsta && rd_pend_q) begin
            HRDATA = ram_doutb;
            if (fwd_valid_q && (rd_addr_q == fwd_addr_q)) begin
                for (int i = 0; i < 4; i++) begin
                    if (fwd_mask_q[i]) begin
                        HRDATA[8*i +: 8] = fwd_data_q[8*i +: 8];
                    end
                end
            end
        end
    end

endmodule
